// File: rtl/line_transfer_engine_pkg.sv
// Shared types for the line transfer engine.
// Holds the transfer FSM states and the array op-size encoding.
package torrence_types;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } memory_operation_size_e;

  localparam memory_operation_size_e BYTE = SZ_BYTE;
  localparam memory_operation_size_e WORD = SZ_WORD;

  typedef enum logic [2:0] {
    IDLE,
    WB_SEND,
    FILL_REQ,
    FILL_WAIT,
    DONE
  } xfer_state_e;

endpackage

// File: rtl/line_transfer_engine_counter.sv
// Wrap-around word pointer plus terminal beat counter.
// Load sets the start word; each step advances both.
module line_word_counter #(
  parameter int WORDS_PER_LINE = 8,
  parameter int WORD_W = $clog2(WORDS_PER_LINE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] start,
  input  logic              step,
  output logic [WORD_W-1:0] wp,
  output logic              last
);

  logic [WORD_W-1:0] wp_q, wp_d;
  logic [WORD_W-1:0] bc_q, bc_d;

  always_comb begin
    wp_d = wp_q;
    bc_d = bc_q;
    if (load) begin
      wp_d = start;
      bc_d = '0;
    end else if (step) begin
      wp_d = wp_q + 1'b1;
      bc_d = bc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      bc_q <= '0;
    end else begin
      wp_q <= wp_d;
      bc_q <= bc_d;
    end
  end

  assign wp   = wp_q;
  assign last = (bc_q == WORD_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/line_transfer_engine.sv
// Cache line fill / writeback engine, one word per memory beat.
// TORRENCE_CRITICAL_WORD_FIRST_EN: fills start at req_word.
module line_transfer_engine
  import torrence_types::*;
#(
  parameter int XLEN           = 32,
  parameter int NUM_SETS       = 4,
  parameter int SET_SIZE       = 2,
  parameter int WORDS_PER_LINE = 8,
  parameter int ASSOC          = 1,
  parameter int WAY_W  = (ASSOC > 1) ? $clog2(ASSOC) : 1,
  parameter int WORD_W = $clog2(WORDS_PER_LINE),
  parameter int TAG_SIZE = XLEN - SET_SIZE - WORD_W - 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_writeback,
  input  logic [SET_SIZE-1:0] req_set,
  input  logic [WAY_W-1:0]    req_way,
  input  logic [TAG_SIZE-1:0] req_tag,
  input  logic [WORD_W-1:0]   req_word,
  output logic                done,
  output logic                arr_write,
  output logic [SET_SIZE-1:0] arr_set,
  output logic [WAY_W-1:0]    arr_way,
  output logic [WORD_W-1:0]   arr_word,
  output logic [XLEN-1:0]     arr_wdata,
  input  logic [XLEN-1:0]     arr_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_we,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_rsp_valid,
  input  logic [XLEN-1:0]     mem_rsp_rdata
);

  if (NUM_SETS > (1 << SET_SIZE)) begin : g_bad_sets
    $error("NUM_SETS does not fit SET_SIZE");
  end

  xfer_state_e         state_q, state_d;
  logic [SET_SIZE-1:0] set_q, set_d;
  logic [WAY_W-1:0]    way_q, way_d;
  logic [TAG_SIZE-1:0] tag_q, tag_d;
  logic                wb_q, wb_d;
  logic                load, step, last;
  logic [WORD_W-1:0]   wp, start_word;

`ifdef TORRENCE_CRITICAL_WORD_FIRST_EN
  assign start_word = req_writeback ? '0 : req_word;
`else
  logic unused_req_word;
  assign unused_req_word = ^req_word;
  assign start_word = '0;
`endif

  line_word_counter #(
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .WORD_W(WORD_W)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .start(start_word),
    .step (step),
    .wp   (wp),
    .last (last)
  );

  always_comb begin
    state_d       = state_q;
    set_d         = set_q;
    way_d         = way_q;
    tag_d         = tag_q;
    wb_d          = wb_q;
    load          = 1'b0;
    step          = 1'b0;
    req_ready     = 1'b0;
    done          = 1'b0;
    arr_write     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          load    = 1'b1;
          set_d   = req_set;
          way_d   = req_way;
          tag_d   = req_tag;
          wb_d    = req_writeback;
          state_d = req_writeback ? WB_SEND : FILL_REQ;
        end
      end
      WB_SEND: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        if (mem_req_ready) begin
          step = 1'b1;
          if (last) state_d = DONE;
        end
      end
      FILL_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = FILL_WAIT;
      end
      FILL_WAIT: begin
        if (mem_rsp_valid) begin
          arr_write = 1'b1;
          step      = 1'b1;
          state_d   = last ? DONE : FILL_REQ;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      set_q   <= '0;
      way_q   <= '0;
      tag_q   <= '0;
      wb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      way_q   <= way_d;
      tag_q   <= tag_d;
      wb_q    <= wb_d;
    end
  end

  assign arr_set   = set_q;
  assign arr_way   = way_q;
  assign arr_word  = wp;
  assign arr_wdata = mem_rsp_rdata;
  assign mem_addr  = {tag_q, set_q, wp, 2'b00};
  assign mem_wdata = arr_rdata;

  logic unused_wb;
  assign unused_wb = wb_q;

endmodule

// File: tb/tb_line_transfer_engine.sv
// Randomized self-checking bench for line_transfer_engine.
// Bench acts as both the data array and the memory.
module tb_line_transfer_engine;

  localparam int TAGW = 25;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_writeback = 1'b0;
  logic [1:0]  req_set = '0;
  logic [0:0]  req_way = '0;
  logic [TAGW-1:0] req_tag = '0;
  logic [2:0]  req_word = '0;
  logic        done;
  logic        arr_write;
  logic [1:0]  arr_set;
  logic [0:0]  arr_way;
  logic [2:0]  arr_word;
  logic [31:0] arr_wdata;
  logic [31:0] arr_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic        mem_req_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_rdata = '0;

  always #5 clk = ~clk;

  line_transfer_engine dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_writeback(req_writeback),
    .req_set      (req_set),
    .req_way      (req_way),
    .req_tag      (req_tag),
    .req_word     (req_word),
    .done         (done),
    .arr_write    (arr_write),
    .arr_set      (arr_set),
    .arr_way      (arr_way),
    .arr_word     (arr_word),
    .arr_wdata    (arr_wdata),
    .arr_rdata    (arr_rdata),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_we   (mem_req_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata)
  );

  logic [31:0] arr_mem [4][8];
  logic [31:0] arr_exp [4][8];
  assign arr_rdata = arr_mem[arr_set][arr_word];

  int n_chk = 0;
  int n_fail = 0;
  bit fill_lin = 1'b1;
  logic [31:0] fill_base = 32'hA0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (fill_lin) return fill_base + {29'd0, a[4:2]};
    return a ^ 32'hC3A5_0F1E ^ {a[15:0], a[31:16]};
  endfunction

  task automatic idle_chk();
    chk("idle_req_ready", req_ready, 1);
    chk("idle_done", done, 0);
    chk("idle_mem_valid", mem_req_valid, 0);
    chk("idle_arr_write", arr_write, 0);
  endtask

  // mode: 0 zero-wait, 1 ready toggles, 2 random ready/latency
  task automatic run_xfer(input bit wb, input logic [1:0] set,
                          input logic [TAGW-1:0] tag,
                          input logic [2:0] word, input int mode,
                          input bit spur, input bit hold,
                          input int abort_after, input int exp_lat);
    int start, beats, writes, dly;
    bit pend, stalled, fin;
    logic [31:0] paddr, s_addr, s_wdata, ea;
    logic s_we;
    logic [2:0] w;
    start = 0;
`ifdef TORRENCE_CRITICAL_WORD_FIRST_EN
    if (!wb) start = int'(word);
`endif
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_writeback = wb;
    req_set = set;
    req_way = '0;
    req_tag = tag;
    req_word = word;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("accept_ready", req_ready, 1);
    chk("accept_no_done", done, 0);
    beats = 0; writes = 0; dly = 0;
    pend = 0; stalled = 0; fin = 0;
    paddr = '0; s_addr = '0; s_wdata = '0; s_we = 0;
    for (int cyc = 1; cyc <= 300 && !fin; cyc++) begin
      @(posedge clk); #1;
      if (!hold) req_valid = 1'b0;
      case (mode)
        0: mem_req_ready = 1'b1;
        1: mem_req_ready = cyc[0];
        default: mem_req_ready = 1'($urandom_range(0, 1));
      endcase
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = $urandom;
      if (pend) begin
        if (dly == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = mem_fn(paddr);
        end else dly--;
      end else if (spur && $urandom_range(0, 2) == 0) begin
        mem_rsp_valid = 1'b1;
      end
      @(negedge clk);
      chk("busy_not_ready", req_ready, 0);
      if (stalled) begin
        chk("stall_valid", mem_req_valid, 1);
        chk("stall_addr", mem_addr, s_addr);
        chk("stall_we", mem_req_we, s_we);
        chk("stall_wdata", mem_wdata, s_wdata);
      end
      if (mem_req_valid) begin
        chk("mem_we", mem_req_we, wb);
        if (!wb) chk("one_outstanding", pend, 0);
      end
      if (pend && mem_rsp_valid) chk("fill_write_en", arr_write, 1);
      else chk("no_stray_write", arr_write, 0);
      if (arr_write) begin
        w = 3'(start + writes);
        ea = {tag, set, w, 2'b00};
        chk("arr_word", arr_word, w);
        chk("arr_set", arr_set, set);
        chk("arr_wdata", arr_wdata, mem_fn(ea));
        arr_mem[arr_set][arr_word] = arr_wdata;
        arr_exp[set][w] = mem_fn(ea);
        writes++;
        pend = 0;
      end
      if (mem_req_valid && mem_req_ready) begin
        w = 3'(start + beats);
        ea = {tag, set, w, 2'b00};
        chk("mem_addr", mem_addr, ea);
        if (wb) chk("wb_data", mem_wdata, arr_exp[set][w]);
        else begin
          pend = 1;
          paddr = ea;
          dly = (mode == 2) ? int'($urandom_range(0, 2)) : 0;
        end
        beats++;
      end
      stalled = mem_req_valid && !mem_req_ready;
      s_addr = mem_addr;
      s_we = mem_req_we;
      s_wdata = mem_wdata;
      if (done) begin
        chk("done_beats", beats, 8);
        if (!wb) chk("done_writes", writes, 8);
        if (exp_lat > 0) chk("latency", cyc, exp_lat);
        fin = 1;
      end
      if (abort_after > 0 && writes == abort_after) begin
        @(posedge clk); #1;
        rst_n = 1'b0;
        mem_rsp_valid = 1'b0;
        #1;
        idle_chk();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_done", done, 0);
          chk("abort_idle", req_ready, 1);
        end
        return;
      end
    end
    if (!fin) chk("timeout_done", fin, 1);
  endtask

  initial begin
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < 8; i++) begin
        arr_mem[s][i] = $urandom;
        arr_exp[s][i] = arr_mem[s][i];
      end
    @(negedge clk);
    idle_chk();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    idle_chk();

    fill_lin = 1'b1;
    fill_base = 32'hA0;
    run_xfer(0, 2'd2, 25'h1234, 3'd0, 0, 0, 0, 0, 17);
    for (int i = 0; i < 8; i++) chk("fill_line", arr_mem[2][i], 32'hA0 + i);
    run_xfer(1, 2'd2, 25'h0777, 3'd0, 0, 0, 0, 0, 9);

    for (int i = 0; i < 8; i++) begin
      arr_mem[1][i] = 32'hB0 + i;
      arr_exp[1][i] = 32'hB0 + i;
    end
    run_xfer(1, 2'd1, 25'h0ABC, 3'd0, 1, 0, 0, 0, 0);

    fill_base = 32'hC0;
    run_xfer(0, 2'd3, 25'h0042, 3'd6, 0, 0, 0, 0, 17);

    fill_base = 32'hD0;
    run_xfer(0, 2'd0, 25'h0100, 3'd0, 0, 0, 0, 3, 0);
    fill_base = 32'hE0;
    run_xfer(0, 2'd0, 25'h0200, 3'd0, 0, 0, 0, 0, 17);
    for (int i = 0; i < 8; i++) chk("refill_line", arr_mem[0][i], 32'hE0 + i);

    fill_lin = 1'b0;
    run_xfer(0, 2'd1, 25'h1F00, 3'd2, 2, 1, 1, 0, 0);
    run_xfer(0, 2'd3, 25'h0F0F, 3'd5, 2, 1, 0, 0, 0);

    for (int t = 0; t < 20; t++) begin
      run_xfer(1'($urandom), 2'($urandom), TAGW'($urandom),
               3'($urandom), int'($urandom_range(0, 2)),
               1'($urandom), 1'b0, 0, 0);
    end

    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    idle_chk();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
